// File: rtl/frogger_game_fsm_if.sv
// Control/status bundle between the Frogger game-flow controller and the
// switch, detector, character, obstacle and display blocks.
interface frogger_game_fsm_if;
  logic       i_Start;
  logic       i_Pause;
  logic       i_Frame_Tick;
  logic       i_Has_Collided;
  logic       i_Reached_Goal;
  logic [2:0] o_State;
  logic       o_Game_Active;
  logic       o_Freeze;
  logic       o_Respawn;
  logic       o_Level_Up;
  logic [2:0] o_Lives;
  logic [3:0] o_Level;
  logic       o_Game_Over;

  // Environment side: drives requests and detector levels, observes controls.
  modport master (
    output i_Start, i_Pause, i_Frame_Tick, i_Has_Collided, i_Reached_Goal,
    input  o_State, o_Game_Active, o_Freeze, o_Respawn, o_Level_Up,
           o_Lives, o_Level, o_Game_Over
  );

  // Controller side.
  modport slave (
    input  i_Start, i_Pause, i_Frame_Tick, i_Has_Collided, i_Reached_Goal,
    output o_State, o_Game_Active, o_Freeze, o_Respawn, o_Level_Up,
           o_Lives, o_Level, o_Game_Over
  );
endinterface

// File: rtl/frogger_game_fsm.sv
// Frogger game-flow controller: lives, levels, pause, timed death / level-up
// banners and a game-over hold, driving enable/freeze/respawn controls.
module frogger_game_fsm #(
  parameter int unsigned C_LIVES_INI    = 3,
  parameter int unsigned C_MAX_LEVEL    = 15,
  parameter int unsigned C_DEATH_FRAMES = 60,
  parameter int unsigned C_LEVEL_FRAMES = 30,
  parameter int unsigned C_OVER_FRAMES  = 120
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  frogger_game_fsm_if.slave    bus
);

  localparam int unsigned LIVES_W = 3;
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUNNING   = 3'd1,
    S_PAUSED    = 3'd2,
    S_DYING     = 3'd3,
    S_LEVEL_UP  = 3'd4,
    S_GAME_OVER = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 respawn_q, respawn_d;
  logic                 level_up_q, level_up_d;
  logic                 active_q, freeze_q, over_q;
  // Hold "input was low last cycle" so a level already high out of reset never fires.
  logic                 start_low_q, pause_low_q;
  logic                 start_edge, pause_edge;

  assign start_edge = bus.i_Start & start_low_q;
  assign pause_edge = bus.i_Pause & pause_low_q;

  // Next-state, counters and pulse generation.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    respawn_d  = 1'b0;
    level_up_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d   = S_RUNNING;
          lives_d   = LIVES_W'(C_LIVES_INI);
          level_d   = LEVEL_W'(1);
          respawn_d = 1'b1;
        end
      end
      S_RUNNING: begin
        if (bus.i_Has_Collided) begin
          if (lives_q <= LIVES_W'(1)) begin
            lives_d = '0;
            state_d = S_GAME_OVER;
          end else begin
            lives_d = lives_q - LIVES_W'(1);
            state_d = S_DYING;
          end
        end else if (bus.i_Reached_Goal) begin
          if (level_q < LEVEL_W'(C_MAX_LEVEL)) level_d = level_q + LEVEL_W'(1);
          level_up_d = 1'b1;
          state_d    = S_LEVEL_UP;
        end else if (pause_edge) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_edge) state_d = S_RUNNING;
      end
      S_DYING: begin
        if (cnt_q == CNT_W'(C_DEATH_FRAMES)) begin
          state_d   = S_RUNNING;
          respawn_d = 1'b1;
        end else if (bus.i_Frame_Tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LEVEL_UP: begin
        if (cnt_q == CNT_W'(C_LEVEL_FRAMES)) begin
          state_d   = S_RUNNING;
          respawn_d = 1'b1;
        end else if (bus.i_Frame_Tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAME_OVER: begin
        if (start_edge && cnt_q == CNT_W'(C_OVER_FRAMES)) begin
          state_d   = S_RUNNING;
          lives_d   = LIVES_W'(C_LIVES_INI);
          level_d   = LEVEL_W'(1);
          respawn_d = 1'b1;
        end else if (bus.i_Frame_Tick && cnt_q < CNT_W'(C_OVER_FRAMES)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      lives_q     <= LIVES_W'(C_LIVES_INI);
      level_q     <= LEVEL_W'(1);
      cnt_q       <= '0;
      respawn_q   <= 1'b0;
      level_up_q  <= 1'b0;
      active_q    <= 1'b0;
      freeze_q    <= 1'b0;
      over_q      <= 1'b0;
      start_low_q <= 1'b0;
      pause_low_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      respawn_q   <= respawn_d;
      level_up_q  <= level_up_d;
      active_q    <= (state_d == S_RUNNING);
      freeze_q    <= (state_d == S_PAUSED) || (state_d == S_DYING) || (state_d == S_LEVEL_UP);
      over_q      <= (state_d == S_GAME_OVER);
      start_low_q <= ~bus.i_Start;
      pause_low_q <= ~bus.i_Pause;
    end
  end

  assign bus.o_State       = state_q;
  assign bus.o_Game_Active = active_q;
  assign bus.o_Freeze      = freeze_q;
  assign bus.o_Respawn     = respawn_q;
  assign bus.o_Level_Up    = level_up_q;
  assign bus.o_Lives       = lives_q;
  assign bus.o_Level       = level_q;
  assign bus.o_Game_Over   = over_q;

endmodule

// File: doc/frogger_game_fsm.md
Name: frogger_game_fsm

Overview:
Parametrised game-flow controller replacing the two-state IDLE/RUNNING machine in the Frogger top level. It adds lives, levels, pause, timed death and level-up sequences, and a game-over hold. It sits between the debounced switches, the collision and goal detectors, and the character, obstacle and display blocks. It drives their enable, freeze and respawn controls.

Parameters:
C_LIVES_INI, 3, lives loaded at game start (1..7)
C_MAX_LEVEL, 15, highest level; level saturates here (1..15)
C_DEATH_FRAMES, 60, frames spent in DYING before respawn (1..255)
C_LEVEL_FRAMES, 30, frames spent in LEVEL_UP banner (1..255)
C_OVER_FRAMES, 120, minimum frames in GAME_OVER before a restart is accepted (1..255)

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  asynchronous active-high reset
i_Start  in  1  start request (all four debounced switches pressed), level signal
i_Pause  in  1  pause toggle request, level signal
i_Frame_Tick  in  1  one-cycle pulse per video frame (VSync start)
i_Has_Collided  in  1  frog/car collision, level signal
i_Reached_Goal  in  1  frog in goal row, level signal
o_State  out  3  encoded state: 0 IDLE, 1 RUNNING, 2 PAUSED, 3 DYING, 4 LEVEL_UP, 5 GAME_OVER
o_Game_Active  out  1  high only in RUNNING
o_Freeze  out  1  high in PAUSED, DYING, LEVEL_UP; obstacles hold position
o_Respawn  out  1  one-cycle pulse; frog returns to base position
o_Level_Up  out  1  one-cycle pulse when a level increment is committed
o_Lives  out  3  remaining lives
o_Level  out  4  current level, 1-based
o_Game_Over  out  1  high in GAME_OVER

Behaviour:
- Reset (asynchronous, any time including mid-sequence): state IDLE, o_Lives=C_LIVES_INI, o_Level=1, frame counter 0, all pulses 0, edge-detect registers 0.
- i_Start and i_Pause are rising-edge detected internally with one registered copy each. A held input fires once. An input already high at reset release does not fire.
- All outputs are registered. State-derived outputs change in the cycle after the transition edge.
- IDLE: start edge -> RUNNING. Load lives=C_LIVES_INI and level=1. Pulse o_Respawn.
- RUNNING, evaluated each cycle in this priority:
  1. collision -> DYING. Lives decrement; if lives was 1, lives=0 and the next state is GAME_OVER directly.
  2. goal -> LEVEL_UP. Level increments, saturating at C_MAX_LEVEL. o_Level_Up pulses even when saturated.
  3. pause edge -> PAUSED.
- Collision and goal asserted in the same cycle: collision wins; level is unchanged.
- PAUSED: pause edge -> RUNNING. Collision, goal and start are ignored. Frame counter does not run.
- DYING: count i_Frame_Tick pulses from 0. When the count reaches C_DEATH_FRAMES -> RUNNING, counter cleared, o_Respawn pulses once. Inputs ignored.
- LEVEL_UP: same mechanism with C_LEVEL_FRAMES. Exit -> RUNNING with an o_Respawn pulse.
- GAME_OVER: count frames, saturating at C_OVER_FRAMES. A start edge is accepted only once the count equals C_OVER_FRAMES; it then behaves as the IDLE start (reload, respawn pulse). Earlier start edges are discarded, not queued.
- Frame counter is 8 bits. It clears on every state entry and never wraps.
- Illegal state encodings (6, 7) -> IDLE on the next clock.
- i_Frame_Tick arriving in the exit cycle is not carried into the next state.

Test Plan:
- Reset release with i_Start high, then held for 100 cycles -> remains IDLE. Drop then raise i_Start -> RUNNING; o_Lives=3, o_Level=1, o_Respawn pulses 1 cycle.
- RUNNING, collision pulse -> DYING, o_Lives=2, o_Freeze=1. After 60 frame ticks -> RUNNING with one o_Respawn pulse. The 59th tick must not exit.
- Collision and goal in the same cycle -> DYING, level stays 1. Goal alone 15 times with C_MAX_LEVEL=15 -> o_Level=15, 15 o_Level_Up pulses, no wrap to 0.
- Three collisions from lives=3 -> GAME_OVER with o_Lives=0. Start edge at frame 50 is ignored. Start edge after frame 120 -> RUNNING with lives=3, level=1.
- Pause edge in RUNNING -> PAUSED. Collision held for 10 cycles -> no change. Pause edge -> RUNNING.
- Assert i_Reset mid-DYING (frame 30) -> immediate IDLE, lives=3, counter 0. Stays IDLE after release.
